// File: rtl/ssd_pkg.sv
// Shared segment encodings and BCD-to-segment decode for the scan driver.
// Patterns are active-low {a,b,c,d,e,f,g,dp}; bit 0 (dp) is off in every constant.
package ssd_pkg;

  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_F     = 8'b0111_0001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  // Non-BCD codes show "F" so bad upstream data is visible rather than hidden.
  function automatic logic [7:0] digit_to_seg(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational decoder from a 4-bit digit code to an active-low segment pattern.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  assign seg = digit_to_seg(code);

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver: one shared segment bus, one anode per digit,
// with per-frame input snapshots, leading-zero blanking, decimal points and blinking.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RW-1:0] RC_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(BLINK_FRAMES - 1);

  logic [RW-1:0]         refresh_cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_on;
  logic                  wrapped;
  logic                  snap_valid;
  logic [4*DIGITS-1:0]   snap_digits;
  logic [DIGITS-1:0]     snap_dp;
  logic                  snap_lz;
  logic [DIGITS-1:0]     snap_blink;

  logic                  term;
  logic                  wrap;
  logic                  load;
  logic [3:0]            cur_code;
  logic [7:0]            dec_seg;
  logic [DIGITS-1:0]     lz_blank;
  logic                  zero_above;
  logic                  digit_blank;
  logic [7:0]            pattern;

  assign term = (refresh_cnt == RC_LAST);
  assign wrap = term && (idx == IDX_LAST);
  // The snapshot is taken during digit 0's dead cycle, so no visible cycle mixes old and new data.
  assign load = (refresh_cnt == '0) && (idx == '0) && (wrapped || !snap_valid);

  assign cur_code = snap_digits[{idx, 2'b00} +: 4];

  ssd_seg_decode u_decode (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    lz_blank   = '0;
    zero_above = snap_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (snap_digits[4*i +: 4] == 4'd0);
      lz_blank[i] = zero_above;
    end
  end

  assign digit_blank = lz_blank[idx] || (!blink_on && snap_blink[idx]);
  assign pattern     = digit_blank ? SEG_BLANK
                                   : {dec_seg[7:1], dec_seg[0] & ~snap_dp[idx]};

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_on    <= 1'b1;
      wrapped     <= 1'b0;
      snap_valid  <= 1'b0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      snap_blink  <= '0;
      seg_out     <= SEG_BLANK;
      an_out      <= '1;
      frame_done  <= 1'b0;
    end else if (!en) begin
      seg_out    <= SEG_BLANK;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= load && wrapped;
      an_out     <= (refresh_cnt == '0) ? '1 : ~(DIGITS'(1) << idx);
      seg_out    <= (refresh_cnt == '0) ? SEG_BLANK : pattern;

      if (load) begin
        snap_digits <= digits;
        snap_dp     <= dp_in;
        snap_lz     <= blank_lz;
        snap_blink  <= blink_mask;
        snap_valid  <= 1'b1;
        wrapped     <= 1'b0;
      end

      if (term) begin
        refresh_cnt <= '0;
        idx         <= wrap ? '0 : idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (wrap) begin
        wrapped <= 1'b1;
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] P0 = 8'b0000_0011;
  localparam logic [7:0] P1 = 8'b1001_1111;
  localparam logic [7:0] P2 = 8'b0010_0101;
  localparam logic [7:0] P3 = 8'b0000_1101;
  localparam logic [7:0] P4 = 8'b1001_1001;
  localparam logic [7:0] P5 = 8'b0100_1001;
  localparam logic [7:0] P9DP = 8'b0000_1000;
  localparam logic [7:0] PF = 8'b0111_0001;
  localparam logic [7:0] PB = 8'hFF;

  always #5 clk = ~clk;

  ssd_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  // k counts enabled cycles since the first enabled edge; k=0 is digit 0's dead cycle.
  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (k % 4 == 0) return 4'hF;
    return ~(one << ((k % 16) / 4));
  endfunction

  function automatic logic exp_fd(input int k);
    return (k % 16 == 0) && (k > 0);
  endfunction

  task automatic apply_reset(input logic en_after);
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = en_after;
  endtask

  task automatic test_reset;
    digits = 16'h1234; dp_in = 4'hF; blank_lz = 1'b0; blink_mask = 4'h0;
    rst = 1'b1; en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== PB || an_out !== 4'hF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold c=%0d: seg=%b an=%b fd=%b, expected seg=11111111 an=1111 fd=0", c, seg_out, an_out, frame_done);
      end
    end
    rst = 1'b0; en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== PB || an_out !== 4'hF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL dark_en0 c=%0d: seg=%b an=%b fd=%b, expected seg=11111111 an=1111 fd=0", c, seg_out, an_out, frame_done);
      end
    end
  endtask

  task automatic test_basic_scan;
    logic [7:0] pats [4];
    logic [7:0] es;
    pats = '{P4, P3, P2, P1};
    digits = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0; blink_mask = 4'h0;
    apply_reset(1'b1);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      es = (k % 4 == 0) ? PB : pats[(k % 16) / 4];
      checks++;
      if (an_out !== exp_an(k)) begin
        errors++;
        $display("FAIL scan_an k=%0d: got %b, expected %b", k, an_out, exp_an(k));
      end
      checks++;
      if (seg_out !== es) begin
        errors++;
        $display("FAIL scan_seg k=%0d: got %b, expected %b", k, seg_out, es);
      end
      checks++;
      if (frame_done !== exp_fd(k)) begin
        errors++;
        $display("FAIL scan_fd k=%0d: got %b, expected %b", k, frame_done, exp_fd(k));
      end
    end
  endtask

  task automatic test_lz_overflow;
    logic [7:0] pats [4];
    logic [7:0] es;
    digits = 16'h00A0; dp_in = 4'h0; blank_lz = 1'b1; blink_mask = 4'h0;
    apply_reset(1'b1);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k < 16) pats = '{P0, PF, PB, PB};
      else        pats = '{P0, PF, P0, P0};
      es = (k % 4 == 0) ? PB : pats[(k % 16) / 4];
      checks++;
      if (seg_out !== es || an_out !== exp_an(k)) begin
        errors++;
        $display("FAIL lz_seg k=%0d: seg=%b an=%b, expected seg=%b an=%b", k, seg_out, an_out, es, exp_an(k));
      end
      if (k == 5) blank_lz = 1'b0;
    end
  endtask

  task automatic test_snapshot_dp;
    logic [7:0] es;
    digits = 16'h0005; dp_in = 4'h0; blank_lz = 1'b1; blink_mask = 4'h0;
    apply_reset(1'b1);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k % 4 == 0 || (k % 16) / 4 != 0) es = PB;
      else es = (k < 16) ? P5 : P9DP;
      checks++;
      if (seg_out !== es) begin
        errors++;
        $display("FAIL snap_seg k=%0d: got %b, expected %b", k, seg_out, es);
      end
      checks++;
      if (frame_done !== exp_fd(k)) begin
        errors++;
        $display("FAIL snap_fd k=%0d: got %b, expected %b", k, frame_done, exp_fd(k));
      end
      if (k == 1) begin
        digits = 16'h0009;
        dp_in  = 4'b0001;
      end
    end
  endtask

  task automatic test_blink;
    logic [7:0] pats [4];
    logic [7:0] es;
    int f;
    digits = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0; blink_mask = 4'b0001;
    apply_reset(1'b1);
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      f = k / 16;
      pats = '{P4, P3, P2, P1};
      if (f == 2 || f == 3) pats[0] = PB;
      es = (k % 4 == 0) ? PB : pats[(k % 16) / 4];
      checks++;
      if (seg_out !== es || an_out !== exp_an(k)) begin
        errors++;
        $display("FAIL blink k=%0d frame=%0d: seg=%b an=%b, expected seg=%b an=%b", k, f, seg_out, an_out, es, exp_an(k));
      end
    end
  endtask

  task automatic test_enable_hold;
    logic [7:0] pats [4];
    logic [7:0] es;
    pats = '{P4, P3, P2, P1};
    digits = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0; blink_mask = 4'h0;
    apply_reset(1'b1);
    for (int k = 0; k < 21; k++) begin
      if (k == 6) begin
        en = 1'b0;
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          checks++;
          if (seg_out !== PB || an_out !== 4'hF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL hold_dark c=%0d: seg=%b an=%b fd=%b, expected seg=11111111 an=1111 fd=0", c, seg_out, an_out, frame_done);
          end
        end
        en = 1'b1;
      end
      @(negedge clk);
      es = (k % 4 == 0) ? PB : pats[(k % 16) / 4];
      checks++;
      if (seg_out !== es || an_out !== exp_an(k) || frame_done !== exp_fd(k)) begin
        errors++;
        $display("FAIL hold_resume k=%0d: seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b", k, seg_out, an_out, frame_done, es, exp_an(k), exp_fd(k));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pats [4];
    logic [7:0] es;
    pats = '{P4, P3, P2, P1};
    digits = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0; blink_mask = 4'h0;
    apply_reset(1'b1);
    for (int k = 0; k < 10; k++) @(negedge clk);
    checks++;
    if (an_out !== 4'b1011) begin
      errors++;
      $display("FAIL midrst_pre: an=%b, expected 1011", an_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (seg_out !== PB || an_out !== 4'hF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dark: seg=%b an=%b fd=%b, expected seg=11111111 an=1111 fd=0", seg_out, an_out, frame_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      es = (k % 4 == 0) ? PB : pats[(k % 16) / 4];
      checks++;
      if (seg_out !== es || an_out !== exp_an(k) || frame_done !== exp_fd(k)) begin
        errors++;
        $display("FAIL midrst_restart k=%0d: seg=%b an=%b fd=%b, expected seg=%b an=%b fd=%b", k, seg_out, an_out, frame_done, es, exp_an(k), exp_fd(k));
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; digits = '0; dp_in = '0; blank_lz = 1'b0; blink_mask = '0;
    @(negedge clk);
    test_reset;
    test_basic_scan;
    test_lz_overflow;
    test_snapshot_dp;
    test_blink;
    test_enable_hold;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
